// File: rtl/systolic_skew_feeder_if.sv
// Handshake and data bundle between a tile producer and the systolic skew feeder.
// The feeder takes the slave view; the producer (or bench) takes the master view.
interface systolic_skew_feeder_if #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 16
);
  logic                             start;
  logic [K_WIDTH-1:0]               k_len;
  logic                             in_valid;
  logic                             in_ready;
  logic [SIZE-1:0][DATA_WIDTH-1:0]  a_data;
  logic [SIZE-1:0][DATA_WIDTH-1:0]  b_data;
  logic [SIZE-1:0][DATA_WIDTH-1:0]  west_inputs;
  logic [SIZE-1:0][DATA_WIDTH-1:0]  north_inputs;
  logic                             accum_reset;
  logic                             busy;
  logic                             done;

  modport master (
    output start, k_len, in_valid, a_data, b_data,
    input  in_ready, west_inputs, north_inputs, accum_reset, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_data, b_data,
    output in_ready, west_inputs, north_inputs, accum_reset, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder for a SIZE x SIZE systolic array: accepts one k-step per beat,
// delays lane i by i cycles, and sequences accumulator clear, feed, flush and done.
module systolic_skew_feeder #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  systolic_skew_feeder_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  localparam int FW = $clog2(2 * SIZE);
  // Last beat must travel SIZE-1 lanes of skew plus SIZE-1 PE hops, hence 2*SIZE-1 flush cycles.
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * SIZE - 2);

  state_t             state_reg;
  logic [K_WIDTH-1:0] k_len_reg;
  logic [K_WIDTH-1:0] beat_cnt_reg;
  logic [FW-1:0]      flush_cnt_reg;
  logic               in_ready_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               accum_reset_reg;

  logic fire;
  logic last_beat;

  assign fire      = in_ready_reg && bus.in_valid;
  assign last_beat = (beat_cnt_reg == k_len_reg - K_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      k_len_reg       <= '0;
      beat_cnt_reg    <= '0;
      flush_cnt_reg   <= '0;
      in_ready_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      accum_reset_reg <= 1'b0;
    end else begin
      accum_reset_reg <= 1'b0;
      done_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            k_len_reg       <= bus.k_len;
            state_reg       <= CLEAR;
            accum_reset_reg <= 1'b1;
            busy_reg        <= 1'b1;
          end
        end
        CLEAR: begin
          beat_cnt_reg <= '0;
          if (k_len_reg != '0) begin
            state_reg    <= FEED;
            in_ready_reg <= 1'b1;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        FEED: begin
          if (fire) begin
            if (last_beat) begin
              state_reg     <= FLUSH;
              in_ready_reg  <= 1'b0;
              flush_cnt_reg <= '0;
              beat_cnt_reg  <= '0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + K_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_reg     <= DONE;
            done_reg      <= 1'b1;
            flush_cnt_reg <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + FW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.accum_reset = accum_reset_reg;

  // Lane gi is a gi+1 deep shift register; non-fire cycles push zeros so A and B bubbles stay aligned.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] west_sr  [0:gi];
    logic [DATA_WIDTH-1:0] north_sr [0:gi];

    always_ff @(posedge clk) begin
      if (rst || state_reg == CLEAR) begin
        for (int j = 0; j <= gi; j++) begin
          west_sr[j]  <= '0;
          north_sr[j] <= '0;
        end
      end else begin
        west_sr[0]  <= fire ? bus.a_data[gi] : '0;
        north_sr[0] <= fire ? bus.b_data[gi] : '0;
        for (int j = 1; j <= gi; j++) begin
          west_sr[j]  <= west_sr[j-1];
          north_sr[j] <= north_sr[j-1];
        end
      end
    end

    assign bus.west_inputs[gi]  = west_sr[gi];
    assign bus.north_inputs[gi] = north_sr[gi];
  end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for `systolic_array_16x16`. It accepts one reduction step per beat, carrying a column of A and a row of B. It applies the diagonal skew the array needs (lane i delayed i cycles) and drives `north_inputs` and `west_inputs`. It also sequences `accum_reset`, the feed, the pipeline flush and a `done` pulse, so the array's `result_matrix` is final when `done` is high.

## Interface
- `SIZE`, 16, array dimension; number of lanes per side
- `DATA_WIDTH`, 8, signed element width
- `K_WIDTH`, 16, width of the reduction-length field
- `clk` in 1: single clock; all state changes on the rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a GEMM tile; sampled only in IDLE
- `k_len` in K_WIDTH: number of beats to accept; sampled with `start`
- `in_valid` in 1: beat available
- `in_ready` out 1: feeder accepts a beat; high only in FEED
- `a_data` in SIZE×DATA_WIDTH: A[r][k] for r = 0..SIZE-1 (west lanes)
- `b_data` in SIZE×DATA_WIDTH: B[k][c] for c = 0..SIZE-1 (north lanes)
- `west_inputs` out SIZE×DATA_WIDTH: to the array west edge; lane r is A skewed by r
- `north_inputs` out SIZE×DATA_WIDTH: to the array north edge; lane c is B skewed by c
- `accum_reset` out 1: one-cycle clear of all PE accumulators
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse; array results are final in this cycle

## Operation
- FSM states:
  - IDLE: `in_ready`=0. On `start`, latch `k_len` and go to CLEAR. `start` in any other state is ignored.
  - CLEAR: one cycle. `accum_reset`=1 and all skew registers are zeroed. Go to FEED if the latched `k_len`≠0, else go to DONE.
  - FEED: `in_ready`=1. A beat fires when `in_valid && in_ready`. A beat counter counts to `k_len`. On the final fire, go to FLUSH.
  - FLUSH: `in_ready`=0. Zeros are injected for exactly 2*SIZE-1 cycles, then go to DONE.
  - DONE: one cycle with `done`=1, then return to IDLE.
- Skew: lane i of each side is a shift register of depth i+1, so all outputs are registered.
  - In a cycle with a fire, stage 0 of lane i loads `a_data[i]` / `b_data[i]`.
  - In a cycle without a fire (any state, including FEED stalls), stage 0 loads 0.
- Bubbles insert zeros into A and B lanes together at the same k-slot, so PE(r,c) still pairs A[r][k] with B[k][c]. Zero products leave the sums unchanged.
- Arithmetic: the feeder does none. Data is passed through bit-exact, signed.
- The array accumulates sum over k of A[r][k]·B[k][c]. The PE stages its outputs in registers and accumulates on each edge at which it samples its inputs.
- `k_len` larger than any internal bound is not special: the counter is K_WIDTH wide, and the maximum is 2^K_WIDTH−1 beats.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `accum_reset`=0, `west_inputs`=0, `north_inputs`=0, FSM=IDLE, counters=0.
- `rst` mid-operation returns to IDLE in the next cycle and zeros all skew stages. No `done` is produced, and partial array sums are left as-is. The next tile's CLEAR clears them.
- `start` at edge t: CLEAR in cycle t+1 (`accum_reset`=1, `busy`=1); FEED from cycle t+2.
- A beat fired at edge e appears on lane i outputs at edge e+1+i.
- Last fire at edge T: FLUSH covers cycles T+1 .. T+2*SIZE−1, and `done`=1 in cycle T+2*SIZE.
  - For SIZE=16, `done` comes 32 cycles after the last beat.
  - PE(SIZE−1,SIZE−1) samples the last beat at edge T+2*SIZE−1.
- `k_len`=0: `done` comes two cycles after CLEAR's `start`; the array is all-zero.
- `in_valid` is ignored outside FEED. A beat offered in the DONE or IDLE cycle is not consumed.
- Minimum back-to-back spacing: `start` may be asserted in the cycle `done` is high but is not sampled; it is sampled in the following IDLE cycle.

## Test plan
- Identity tile: SIZE=16, `k_len`=16, A=I, B[k][c]=k*16+c−128 with no stalls → `done` at last fire +32; `result_matrix`=B exactly; `in_ready` high for exactly 16 cycles.
- Skew check: one beat with `a_data` lanes = r+1 and `b_data` lanes = c+1 → `west_inputs[r]` is nonzero only at fire+1+r; `north_inputs[c]` only at fire+1+c; result[r][c]=(r+1)(c+1).
- Stalls: `k_len`=8 with random all-ones data, and `in_valid` toggled 50% → results identical to the stall-free run (each entry 8); `done` at last fire +32.
- Signed extremes: A=−128, B=−128, `k_len`=16 → every entry 262144; A=127, B=−128 → −260096.
- `k_len`=0, and `start` while busy → `accum_reset` pulse, then `done` 2 cycles after CLEAR, with all results 0; a second `start` during FEED does not change the beat count.
- Reset mid-FEED after 5 beats → next cycle IDLE with outputs 0; the following full tile gives the correct results and no stale contributions.
